// File: rtl/dmem_responder.sv
// Data memory responder: one-cycle registered loads, lane-masked stores.
// Two-state FSM (IDLE/RD) holds off new requests while a load is returned.
module dmem_responder #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_en,
  input  logic        mem_wr_en,
  input  logic [0:15] addr,
  input  logic [0:63] data_in,
  input  logic [0:2]  ppp,
  output logic [0:63] data_out,
  output logic        data_valid,
  output logic        busy,
  output logic        err
);

  typedef enum logic {IDLE, RD} state_t;

  state_t        state;
  state_t        state_nxt;
  logic          legal;
  logic          lanes_ok;
  logic          ld_req;
  logic          st_req;
  logic          st_ok;
  logic [0:AW-1] idx;
  logic [0:63]   mask;

  logic [0:63]   mem [DEPTH];

  assign legal  = {16'd0, addr} < 32'(DEPTH);
  assign idx    = addr[16-AW:15];
  assign ld_req = (state == IDLE) && mem_en && !mem_wr_en;
  assign st_req = (state == IDLE) && mem_en && mem_wr_en;
  assign st_ok  = st_req && legal && lanes_ok;

  // Decode the store lane select into a bit mask
  always_comb begin
    mask     = '0;
    lanes_ok = 1'b1;
    unique case (ppp)
      3'b000:  mask = {64{1'b1}};
      3'b001:  mask = {{32{1'b1}}, {32{1'b0}}};
      3'b010:  mask = {{32{1'b0}}, {32{1'b1}}};
      3'b011:  mask = {4{8'hFF, 8'h00}};
      3'b100:  mask = {4{8'h00, 8'hFF}};
      default: lanes_ok = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: accept a load in IDLE, always leave RD after one cycle
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (ld_req) state_nxt = RD;
      RD:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    data_valid = (state == RD);
    busy       = (state == RD);
  end

  // Load data and error pulse; illegal loads still answer, with zero
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out <= '0;
      err      <= 1'b0;
    end else begin
      err <= 1'b0;
      if (ld_req) begin
        data_out <= legal ? mem[idx] : '0;
        err      <= !legal;
      end else if (st_req) begin
        err <= !(legal && lanes_ok);
      end
    end
  end

  // Storage array; never cleared by reset, writes blocked during reset
  always_ff @(posedge clk) begin
    if (!reset && st_ok)
      mem[idx] <= (mem[idx] & ~mask) | (data_in & mask);
  end

endmodule
